nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/ci presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  W  addend A.
REQ-007 b  input  W  addend B.
REQ-008 ci  input  1  initial carry-in.
REQ-009 out_valid  output  1  sum/co hold a completed result.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 sum  output  W  result A+B+ci, modulo 2^W.
REQ-012 co  output  1  carry out of bit W-1.
REQ-013 busy  output  1  high in ADD or DONE state.

Function
REQ-014 The block SHALL compute A+B+ci using exactly one 4-bit adder instance, processing one nibble per clock, LSB nibble first.
REQ-015 FSM states SHALL be IDLE, ADD, DONE; encoding from the shared package.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready, capture a, b into operand shift registers, ci into carry register, clear nibble counter, go to ADD.
REQ-017 ADD: each cycle, feed nibble[cnt] of A, B and the carry register to the adder; store adder s into sum nibble[cnt]; store adder co into carry register; increment cnt.
REQ-018 ADD SHALL last exactly NIB cycles; on the cycle cnt==NIB-1 transition to DONE.
REQ-019 DONE: out_valid=1; sum and co (co = final carry register) SHALL remain stable until out_valid&&out_ready, then go to IDLE.
REQ-020 Latency: handshake accepted at edge k -> out_valid high after edge k+NIB; with out_ready held high, in_ready returns high after edge k+NIB+1.
REQ-021 in_ready SHALL be 0 in ADD and DONE; in_valid in those states SHALL be ignored and SHALL NOT alter captured operands.
REQ-022 Changes on a, b, ci after capture SHALL NOT affect the result.
REQ-023 Carry wrap: carry out of the top nibble SHALL appear only on co; sum SHALL wrap modulo 2^W.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 Nibble counter width SHALL be clog2(NIB) bits minimum; no counter overflow for any legal NIB>=1.

Reset
REQ-026 rst_n low SHALL, immediately and independent of clk, force state=IDLE, cnt=0, carry=0, sum=0, co=0, out_valid=0, busy=0, operand registers=0.
REQ-027 Reset asserted mid-ADD or in DONE SHALL discard the operation; no out_valid pulse after release.
REQ-028 After rst_n deasserts, in_ready SHALL be 1 at the first clk edge.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, ADD, DONE) and the nibble width constant (4).
REQ-030 One sub-module SHALL be instantiated: fa4_mbit (ports s, co, a, b, ci), the team's 4-bit multi-bit adder; no other arithmetic operator on operands.
REQ-031 Datapath (shift/counter/sum registers) and FSM SHALL be in the top module; no additional hierarchy.

Verification
REQ-032 NIB=4, a=0x1234, b=0x4321, ci=0, out_ready=1 -> after 4 cycles out_valid=1, sum=0x5555, co=0.
REQ-033 a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1 (carry ripples through all four nibble cycles).
REQ-034 a=0xFFFF, b=0xFFFF, ci=1 -> sum=0xFFFF, co=1.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid, sum, co stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 in_valid held high with new a/b during ADD -> ignored, first result unchanged; rst_n pulsed low in ADD cycle 2 -> all outputs 0, no out_valid, in_ready=1 after release.
REQ-037 200 random operand sets ({ci,a,b} from $random) with random out_ready -> every result equals golden A+B+ci, latency per REQ-020.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared FSM state encoding and nibble width
package nibble_serial_adder_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;
endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bus; master drives in_valid/a/b/ci/out_ready, slave drives in_ready/out_valid/sum/co/busy
interface nibble_serial_adder_if #(parameter int NIB = 4) ();
  import nibble_serial_adder_pkg::*;
  localparam int W = NIB_W * NIB;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         busy;
  modport master (output in_valid, a, b, ci, out_ready, input in_ready, out_valid, sum, co, busy);
  modport slave  (input in_valid, a, b, ci, out_ready, output in_ready, out_valid, sum, co, busy);
endinterface

// File: rtl/nibble_serial_adder_fa4_mbit.sv
// fa4_mbit: 4-bit adder; ports a, b, ci in, s, co out
module fa4_mbit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: A+B+ci one nibble per clock via a single fa4_mbit; clk, rst_n (async low), bus (slave handshake)
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_serial_adder_if.slave   bus
);
  localparam int W  = NIB_W * NIB;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [NIB_W-1:0] fa_s;
  logic            fa_co;
  fa4_mbit u_fa (
    .a  (a_q[NIB_W-1:0]),
    .b  (b_q[NIB_W-1:0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = ADD;
        a_d     = bus.a;
        b_d     = bus.b;
        carry_d = bus.ci;
        cnt_d   = '0;
      end
      ADD: begin
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        carry_d = fa_co;
        sum_d[int'(cnt_q) * NIB_W +: NIB_W] = fa_s;
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(NIB - 1) ? DONE : ADD;
      end
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.sum       = sum_q;
  assign bus.co        = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed table, corner sequences and random operands against a golden sum
module tb_nibble_serial_adder;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  nibble_serial_adder_if #(.NIB(NIB)) bus ();
  nibble_serial_adder #(.NIB(NIB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] sum;
    logic         co;
    int           hold;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] rsum, input logic rco, input int hold, input bit noise);
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.ci        = ci;
    bus.out_ready = hold == 0;
    @(negedge clk);
    chk("in_ready_add", bus.in_ready, 0);
    bus.in_valid = noise;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.ci       = ~ci;
    cyc = 0;
    while (!bus.out_valid && cyc < 4 * NIB) begin
      @(negedge clk);
      cyc++;
      if (noise) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    chk("latency", cyc, NIB);
    chk("sum", bus.sum, rsum);
    chk("co", bus.co, rco);
    chk("busy_done", bus.busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_sum", bus.sum, rsum);
      chk("hold_co", bus.co, rco);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask
  initial begin
    logic [W:0]   gold;
    logic [W-1:0] ra, rb;
    logic         rci;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 2};
    vecs[6] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 0};
    vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 5};
    vecs[9] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_co", bus.co, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sum, vecs[i].co, vecs[i].hold, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0, 1'b1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3, 1'b1);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = 16'hFFFF;
    bus.b         = 16'hFFFF;
    bus.ci        = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_co", bus.co, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      chk("post_rst_valid", bus.out_valid, 0);
      chk("post_rst_in_ready", bus.in_ready, 1);
    end
    for (int n = 0; n < 200; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rci  = 1'($urandom);
      gold = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
      do_op(ra, rb, rci, gold[W-1:0], gold[W], $urandom_range(0, 2), 1'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
